// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the datapath sequencing controller:
//   - one-hot FSM state encoding (HALT only when CTRL_ILLEGAL_TRAP_EN is defined)
//   - opcode / ALU-op field constants and an instruction classifier
//   - nsel one-hot register-select constants
//   - vsel write-back mux constants
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the HALT state).
// -----------------------------------------------------------------------------
package ctrl_pkg;

  // Latched instruction is {opcode[2:0], op[1:0]}.
  localparam int INSTR_W = 5;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam int STATE_W = 9;
`else
  localparam int STATE_W = 8;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_WAIT   = STATE_W'(1 << 0),
    S_DECODE = STATE_W'(1 << 1),
    S_WR_IMM = STATE_W'(1 << 2),
    S_GET_A  = STATE_W'(1 << 3),
    S_GET_B  = STATE_W'(1 << 4),
    S_ALU    = STATE_W'(1 << 5),
    S_CMP    = STATE_W'(1 << 6),
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_WR_REG = STATE_W'(1 << 7),
    S_HALT   = STATE_W'(1 << 8)
`else
    S_WR_REG = STATE_W'(1 << 7)
`endif
  } state_e;

  // Opcode field values.
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // op field under OP_ALU.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // op field under OP_MOV.
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // Register-file select, one-hot.
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Write-back mux select.
  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_ZERO   = 2'b01;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA  = 2'b11;

  typedef enum logic [2:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_ADD,
    I_AND,
    I_CMP,
    I_MVN,
    I_UNDEF
  } instr_e;

  // Classify a latched {opcode, op} pair.
  function automatic instr_e decode_instr(input logic [INSTR_W-1:0] ir);
    instr_e cls;
    cls = I_UNDEF;
    case (ir)
      {OP_MOV, MOV_IMM}: cls = I_MOV_IMM;
      {OP_MOV, MOV_REG}: cls = I_MOV_REG;
      {OP_ALU, ALU_ADD}: cls = I_ADD;
      {OP_ALU, ALU_AND}: cls = I_AND;
      {OP_ALU, ALU_CMP}: cls = I_CMP;
      {OP_ALU, ALU_MVN}: cls = I_MVN;
      default:           cls = I_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_state_reg.sv
// -----------------------------------------------------------------------------
// ctrl_state_reg
// Plain D register of parameterised width with asynchronous active-low reset
// to RESET_VAL. Used for the FSM state and the latched instruction.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   d_i    in   next value
//   q_o    out  registered value
// -----------------------------------------------------------------------------
module ctrl_state_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from before the clock edge; the async reset
  // puts the register in a known value without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RESET_VAL;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Moore sequencing FSM for the simple RISC datapath. One instruction is
// accepted per start pulse seen in WAIT; {opcode, op} is latched on accept and
// only the latched copy steers the rest of the sequence. All outputs decode
// from the state and the latched instruction, never from s.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- undefined instructions park
// the FSM in HALT and raise the illegal port; otherwise they act as a NOP.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s                       start, sampled only in WAIT
//   opcode[2:0], op[1:0]    instruction fields from the instruction register
//   w                       high only in WAIT (ready)
//   nsel[2:0]               one-hot register select (Rn/Rd/Rm)
//   loada/loadb/loadc/loads load enables for A, B, C and status
//   asel, bsel              ALU input muxes (zero into A, sximm5 into B)
//   vsel[1:0]               write-back mux select
//   write                   register-file write enable
//   illegal                 sticky illegal-instruction flag (trap build only)
// -----------------------------------------------------------------------------
module datapath_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic       write,
  output logic       illegal
`else
  output logic       write
`endif
);

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   state_raw;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  instr_e               instr;

  ctrl_state_reg #(
    .WIDTH     (STATE_W),
    .RESET_VAL (S_WAIT)
  ) u_state_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (state_d),
    .q_o   (state_raw)
  );

  assign state_q = state_e'(state_raw);

  ctrl_state_reg #(
    .WIDTH     (INSTR_W),
    .RESET_VAL ('0)
  ) u_ir_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ir_d),
    .q_o   (ir_q)
  );

  assign instr = decode_instr(ir_q);

  // Next-state and instruction-latch logic.
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = {opcode, op};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (instr)
          I_MOV_IMM:            state_d = S_WR_IMM;
          I_MOV_REG, I_MVN:     state_d = S_GET_B;
          I_ADD, I_AND, I_CMP:  state_d = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:              state_d = S_HALT;
`else
          default:              state_d = S_WAIT;
`endif
        endcase
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = (instr == I_CMP) ? S_CMP : S_ALU;
      S_ALU:    state_d = S_WR_REG;
      S_CMP:    state_d = S_WAIT;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      // Only rst_n leaves HALT.
      S_HALT:   state_d = S_HALT;
`endif
      // Any non-one-hot pattern recovers to WAIT.
      default:  state_d = S_WAIT;
    endcase
  end

  // Moore output decode.
  always_comb begin
    w     = 1'b0;
    nsel  = NSEL_NONE;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_C;
    write = 1'b0;
    unique case (state_q)
      S_WAIT:   w = 1'b1;
      S_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_SXIMM8;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        // MOV Rd,Rm passes B through the ALU as 0 + B.
        asel  = (instr == I_MOV_REG);
      end
      S_CMP:    loads = 1'b1;
      S_WR_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // HALT is only left through reset, so decoding it gives a sticky flag.
  assign illegal = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
// Self-checking bench for datapath_ctrl. A reference model turns each accepted
// instruction into the list of per-cycle output vectors the instruction must
// produce; a compare process checks the DUT against it on every falling edge.
// Directed sequences add hand-computed latency and strobe-count expectations.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       ill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
  assign ill = illegal;
`else
  assign ill = 1'b0;
`endif

  datapath_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .nsel   (nsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .bsel   (bsel),
    .vsel   (vsel),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .write  (write),
    .illegal(illegal)
`else
    .write  (write)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output vector: {marker, w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal}
  function automatic logic [15:0] mk(input logic w_, input logic [2:0] ns,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as_, input logic bs,
                                     input logic [1:0] vs, input logic wr, input logic il);
    return {1'b0, w_, ns, la, lb, lc, ls, as_, bs, vs, wr, il};
  endfunction

  localparam logic [15:0] HALT_MARK = 16'h8000;

  logic [15:0] v_idle, v_wait, v_wrimm, v_geta, v_getb, v_alu, v_alumov, v_cmp, v_wrreg, v_halt;
  initial begin
    v_idle   = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_wait   = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_wrimm  = mk(0, 3'b001, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
    v_geta   = mk(0, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_getb   = mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    v_alu    = mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    v_alumov = mk(0, 3'b000, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0);
    v_cmp    = mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    v_wrreg  = mk(0, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    v_halt   = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
  end

  // Reference model: queue of the output vectors still to come for the
  // instruction in flight; empty means the controller is idle and ready.
  logic [15:0] pending[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending.delete();
    end else if (pending.size() == 0) begin
      if (s) begin
        pending.push_back(v_idle);  // decode cycle, nothing strobed
        case ({opcode, op})
          5'b110_10: pending.push_back(v_wrimm);
          5'b110_00: begin
            pending.push_back(v_getb); pending.push_back(v_alumov); pending.push_back(v_wrreg);
          end
          5'b101_00, 5'b101_10: begin
            pending.push_back(v_geta); pending.push_back(v_getb);
            pending.push_back(v_alu);  pending.push_back(v_wrreg);
          end
          5'b101_01: begin
            pending.push_back(v_geta); pending.push_back(v_getb); pending.push_back(v_cmp);
          end
          5'b101_11: begin
            pending.push_back(v_getb); pending.push_back(v_alu); pending.push_back(v_wrreg);
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            pending.push_back(HALT_MARK);
`endif
          end
        endcase
      end
    end else if (pending[0] != HALT_MARK) begin
      void'(pending.pop_front());
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    logic [15:0] exp_v, act_v;
    if (pending.size() == 0)        exp_v = v_wait;
    else if (pending[0] == HALT_MARK) exp_v = v_halt;
    else                            exp_v = pending[0];
    act_v = {1'b0, w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, ill};
    check("cycle outputs", {16'h0, act_v}, {16'h0, exp_v});
  end

  // Run one instruction from WAIT with a one-cycle start pulse and measure it.
  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                           input bit flip, input int exp_low, input int exp_wr,
                           input int exp_la, input int exp_ls);
    int low, wr, la, ls;
    low = 0; wr = 0; la = 0; ls = 0;
    @(negedge clk);
    s = 1'b1; opcode = opc; op = o;
    @(negedge clk);
    s = 1'b0;
    if (flip) begin
      opcode = 3'b110; op = 2'b10;
    end
    for (int i = 0; i < 40; i++) begin
      if (w) break;
      low++;
      wr += int'(write);
      la += int'(loada);
      ls += int'(loads);
      @(negedge clk);
    end
    check({name, " busy cycles"}, low, exp_low);
    check({name, " write pulses"}, wr, exp_wr);
    check({name, " loada pulses"}, la, exp_la);
    check({name, " loads pulses"}, ls, exp_ls);
  endtask

  initial begin
    int wr_cnt, w_cnt;
    rst_n = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00;
    repeat (2) @(negedge clk);
    check("reset w", w, 1);
    check("reset write", write, 0);
    check("reset nsel", nsel, 0);
    rst_n = 1'b1;

    // MOV R0,#7: w low 2 cycles, one write.
    run_instr("mov_imm", 3'b110, 2'b10, 0, 2, 1, 0, 0);
    // ADD with the IR changed to MOV imm right after accept.
    run_instr("add_flip", 3'b101, 2'b00, 1, 5, 1, 1, 0);
    run_instr("and", 3'b101, 2'b10, 0, 5, 1, 1, 0);
    run_instr("cmp", 3'b101, 2'b01, 0, 4, 0, 1, 1);
    run_instr("mov_reg", 3'b110, 2'b00, 0, 4, 1, 0, 0);
    run_instr("mvn", 3'b101, 2'b11, 0, 4, 1, 0, 0);

    // Reset during ADD while in GET_B.
    @(negedge clk);
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    @(negedge clk);
    s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre-reset loadb", loadb, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort w", w, 1);
    check("abort loadb", loadb, 0);
    check("abort write", write, 0);
    rst_n = 1'b1;
    run_instr("mov_imm_after_rst", 3'b110, 2'b10, 0, 2, 1, 0, 0);

    // s held high: one MOV imm per three cycles, WAIT visited each time.
    @(negedge clk);
    s = 1'b1; opcode = 3'b110; op = 2'b10;
    wr_cnt = 0; w_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      wr_cnt += int'(write);
      w_cnt  += int'(w);
    end
    s = 1'b0;
    check("held s writes", wr_cnt, 4);
    check("held s wait cycles", w_cnt, 4);

`ifdef CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    s = 1'b1; opcode = 3'b111; op = 2'b00;
    @(negedge clk);
    s = 1'b0;
    repeat (20) @(negedge clk);
    check("halt illegal", illegal, 1);
    check("halt w", w, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("halt exit w", w, 1);
    check("halt exit illegal", illegal, 0);
    rst_n = 1'b1;
`else
    run_instr("undef_nop", 3'b111, 2'b00, 0, 1, 0, 0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
